// File: rtl/rstc_pkg.sv
// Shared types and constants for the reset sequencer.
package rstc_pkg;

    localparam int CNT_W       = 4;   // hold/stagger down-counter width
    localparam int RCNT_W      = 8;   // accepted control-unit request counter width
    localparam int HOLD_DEF    = 8;
    localparam int STAGGER_DEF = 2;

    typedef enum logic [2:0] {
        S_POR     = 3'd0,
        S_HOLD    = 3'd1,
        S_REL_MEM = 3'd2,
        S_REL_DP  = 3'd3,
        S_RUN     = 3'd4
    } rstc_state_t;

endpackage

// File: rtl/rstc_dcount.sv
// Loadable down-counter that stops at zero; exposes only the zero flag.
module rstc_dcount
    import rstc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: memory, then datapath, then fetch/PC, with a
// minimum hold after any reset cause and a saturating request counter.
module reset_sequencer
    import rstc_pkg::*;
#(
    parameter int HOLD_CYCLES    = HOLD_DEF,
    parameter int STAGGER_CYCLES = STAGGER_DEF
) (
    input  logic              rstc_clk,
    input  logic              rstc_rst_n,
    input  logic              rstc_por_sel,
    input  logic              rstc_por_rst,
    input  logic              rstc_cu_rst_req,
    output logic              rstc_mem_rst,
    output logic              rstc_dp_rst,
    output logic              rstc_pc_rst,
    output logic              rstc_ready,
    output logic [RCNT_W-1:0] rstc_rst_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LD = CNT_W'(STAGGER_CYCLES - 1);

    rstc_state_t      state, next_state;
    logic             por, cnt_zero, cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             mem_n, dp_n, pc_n, rdy_n, cu_hit;

    assign por = rstc_por_sel | rstc_por_rst;

    // State register.
    always_ff @(posedge rstc_clk) begin
        if (!rstc_rst_n)
            state <= S_POR;
        else
            state <= next_state;
    end

    // Next state: POR beats a control-unit request everywhere.
    always_comb begin
        next_state = S_POR;
        if (!por) begin
            case (state)
                S_POR:     next_state = S_HOLD;
                S_HOLD:    next_state = (cnt_zero && !rstc_cu_rst_req) ? S_REL_MEM : S_HOLD;
                S_REL_MEM: next_state = rstc_cu_rst_req ? S_HOLD : (cnt_zero ? S_REL_DP : S_REL_MEM);
                S_REL_DP:  next_state = rstc_cu_rst_req ? S_HOLD : (cnt_zero ? S_RUN : S_REL_DP);
                S_RUN:     next_state = rstc_cu_rst_req ? S_HOLD : S_RUN;
                default:   next_state = S_POR;
            endcase
        end
    end

    // Counter control: a request seen while holding restarts the hold window.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (next_state == S_HOLD && (state != S_HOLD || rstc_cu_rst_req)) begin
            cnt_load = 1'b1;
            cnt_val  = HOLD_LD;
        end else if ((next_state == S_REL_MEM && state != S_REL_MEM) ||
                     (next_state == S_REL_DP  && state != S_REL_DP)) begin
            cnt_load = 1'b1;
            cnt_val  = STAGGER_LD;
        end else if (next_state == S_POR) begin
            cnt_load = 1'b1;
        end
    end

    rstc_dcount u_dcount (
        .clk      (rstc_clk),
        .rst_n    (rstc_rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Output decode from the next state so the registered outputs track state.
    always_comb begin
        mem_n  = 1'b1;
        dp_n   = 1'b1;
        pc_n   = 1'b1;
        rdy_n  = 1'b0;
        cu_hit = (next_state == S_HOLD) &&
                 (state == S_REL_MEM || state == S_REL_DP || state == S_RUN);
        case (next_state)
            S_REL_MEM: mem_n = 1'b0;
            S_REL_DP: begin
                mem_n = 1'b0;
                dp_n  = 1'b0;
            end
            S_RUN: begin
                mem_n = 1'b0;
                dp_n  = 1'b0;
                pc_n  = 1'b0;
                rdy_n = 1'b1;
            end
            default: ;
        endcase
    end

    // Output registers and saturating request counter.
    always_ff @(posedge rstc_clk) begin
        if (!rstc_rst_n) begin
            rstc_mem_rst <= 1'b1;
            rstc_dp_rst  <= 1'b1;
            rstc_pc_rst  <= 1'b1;
            rstc_ready   <= 1'b0;
            rstc_rst_cnt <= '0;
        end else begin
            rstc_mem_rst <= mem_n;
            rstc_dp_rst  <= dp_n;
            rstc_pc_rst  <= pc_n;
            rstc_ready   <= rdy_n;
            if (cu_hit && rstc_rst_cnt != '1)
                rstc_rst_cnt <= rstc_rst_cnt + 1'b1;
        end
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have a parameter HOLD_CYCLES, default 8 (range 2..15): the minimum number of cycles all reset outputs are held after any reset cause ends.
REQ-002 The block SHALL have a parameter STAGGER_CYCLES, default 2 (range 1..15): the number of cycles between successive domain releases.
REQ-003 rstc_clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rstc_rst_n  in  1  synchronous, active-low reset.
REQ-005 rstc_por_sel  in  1  power-on-reset counter select; 1 = power-on sequence still active.
REQ-006 rstc_por_rst  in  1  power-on-reset counter reset output; active-high.
REQ-007 rstc_cu_rst_req  in  1  control-unit reset request; level, active-high.
REQ-008 rstc_mem_rst  out  1  memory-domain reset; active-high; released first.
REQ-009 rstc_dp_rst  out  1  datapath (register file, ALU) reset; active-high; released second.
REQ-010 rstc_pc_rst  out  1  fetch/PC reset; active-high; released last.
REQ-011 rstc_ready  out  1  1 only when all three domain resets are released.
REQ-012 rstc_rst_cnt  out  8  count of accepted control-unit reset requests; saturating.

Function
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-014 The FSM SHALL have exactly five states: S_POR, S_HOLD, S_REL_MEM, S_REL_DP, S_RUN.
REQ-015 In S_POR, S_HOLD and S_REL_MEM, the outputs SHALL be mem_rst=1, dp_rst=1, pc_rst=1, ready=0, except that mem_rst SHALL be 0 in S_REL_MEM.
REQ-016 In S_REL_DP, the outputs SHALL be mem_rst=0, dp_rst=0, pc_rst=1, ready=0.
REQ-017 In S_RUN, all three domain resets SHALL be 0 and ready SHALL be 1.
REQ-018 S_POR -> S_HOLD SHALL occur when both por_sel=0 and por_rst=0; otherwise the FSM SHALL remain in S_POR.
REQ-019 On entry to S_HOLD, the down-counter SHALL load HOLD_CYCLES-1.
REQ-020 In S_HOLD, the counter SHALL decrement by 1 per cycle and SHALL stop at 0.
REQ-021 S_HOLD -> S_REL_MEM SHALL occur when counter==0 and cu_rst_req==0; with req=1, the FSM SHALL stay in S_HOLD and the counter SHALL reload HOLD_CYCLES-1.
REQ-022 On entry to S_REL_MEM and to S_REL_DP, the counter SHALL load STAGGER_CYCLES-1.
REQ-023 S_REL_MEM -> S_REL_DP and S_REL_DP -> S_RUN SHALL each occur when counter==0.
REQ-024 The first cycle with mem_rst=0 SHALL occur exactly HOLD_CYCLES cycles after S_HOLD entry.
REQ-025 dp_rst SHALL fall STAGGER_CYCLES cycles after mem_rst falls; pc_rst and ready SHALL change STAGGER_CYCLES cycles after dp_rst falls.
REQ-026 cu_rst_req=1 sampled in S_RUN, S_REL_MEM or S_REL_DP SHALL cause a transition to S_HOLD next cycle, with all resets reasserted and ready=0.
REQ-027 rstc_rst_cnt SHALL increment by 1 on each cu_rst_req-caused transition into S_HOLD, and SHALL saturate at 255 (no wrap).
REQ-028 A held req that stays high in S_HOLD SHALL NOT be counted again.
REQ-029 por_sel=1 or por_rst=1 sampled in any state other than S_POR SHALL cause a transition to S_POR next cycle, without incrementing rst_cnt.
REQ-030 When POR and cu_rst_req are asserted simultaneously, POR SHALL take priority.
REQ-031 Illegal state encodings SHALL recover to S_POR on the next edge.

Reset
REQ-032 With rstc_rst_n=0 at a rising edge, the next state SHALL be: state=S_POR, counter=0, mem_rst=dp_rst=pc_rst=1, ready=0, rst_cnt=0.
REQ-033 Reset applied mid-sequence (any state) SHALL abort immediately with the values of REQ-032; rst_n SHALL take priority over all inputs.

Structure
REQ-034 Package rstc_pkg SHALL hold the state enum (rstc_state_t), the counter width constant (4), the rst_cnt width (8) and the default HOLD/STAGGER values.
REQ-035 A single sub-module, rstc_dcount, SHALL implement the load/decrement-to-zero 4-bit counter with a zero flag; there SHALL be one instance.

Verification (HOLD=8, STAGGER=2)
REQ-036 Scenario 1: rst_n=0 for 2 cycles, por_sel=por_rst=1 -> all resets=1, ready=0, rst_cnt=0.
REQ-037 Scenario 2: POR drops at cycle T -> mem_rst falls at T+1+8, dp_rst falls at T+11, pc_rst falls and ready rises at T+13.
REQ-038 Scenario 3: In S_RUN, pulse cu_rst_req for 1 cycle -> all resets=1 next cycle, rst_cnt=1, identical 8/2/2 release thereafter.
REQ-039 Scenario 4: Hold cu_rst_req for 20 cycles -> mem_rst stays 1 until 8 cycles after req falls, rst_cnt increments only once.
REQ-040 Scenario 5: Assert req during S_REL_DP, then POR during S_HOLD -> state returns to S_HOLD then S_POR, rst_cnt increments once, pc_rst never drops.
REQ-041 Scenario 6: 260 single-cycle requests, each after ready rises -> rst_cnt saturates at 255; rst_n=0 mid-S_REL_MEM -> S_POR with rst_cnt=0.
